// File: rtl/reg_file_mp.sv
// Multi-port integer register file with NR read ports, NW write ports, an optional
// write-to-read bypass and a per-register pending-write scoreboard for hazard detection.
module reg_file_mp #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NR       = 2,
  parameter int NW       = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NR*ADDR_W-1:0]   raddr,
  output logic [NR*DATA_W-1:0]   rdata,
  output logic [NR-1:0]          rbusy,
  input  logic [NW-1:0]          we,
  input  logic [NW*ADDR_W-1:0]   waddr,
  input  logic [NW*DATA_W-1:0]   wdata,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [(2**ADDR_W)-1:0] busy_vec
);

  localparam int REG_NUM = 2**ADDR_W;

  logic [DATA_W-1:0]  mem_q [REG_NUM];
  logic [DATA_W-1:0]  mem_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [NW-1:0]      wvalid_s;

  // Write enables with writes to the hard-wired zero register dropped
  always_comb begin
    wvalid_s = {NW{1'b0}};
    for (int j = 0; j < NW; j++) begin
      wvalid_s[j] = we[j] &&
                    !((ZERO_REG != 0) && (waddr[j*ADDR_W +: ADDR_W] == {ADDR_W{1'b0}}));
    end
  end

  // Next-state storage and scoreboard; later write ports override earlier ones
  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      logic clr_s;
      mem_d[r] = mem_q[r];
      clr_s    = 1'b0;
      for (int j = 0; j < NW; j++) begin
        mem_d[r] = (wvalid_s[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)))
                   ? wdata[j*DATA_W +: DATA_W] : mem_d[r];
        clr_s    = clr_s || (we[j] && (waddr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)));
      end
      // A new issue is younger than the retiring write, so set beats clear
      busy_d[r] = (iss_valid && (iss_addr == ADDR_W'(r))) ? 1'b1 :
                  (clr_s ? 1'b0 : busy_q[r]);
    end
    busy_d[0] = (ZERO_REG != 0) ? 1'b0 : busy_d[0];
  end

  // Storage and scoreboard registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        mem_q[r] <= {DATA_W{1'b0}};
      end
      busy_q <= {REG_NUM{1'b0}};
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q <= busy_d;
    end
  end

  // Combinational read ports with optional same-cycle bypass
  always_comb begin
    rdata = {(NR*DATA_W){1'b0}};
    rbusy = {NR{1'b0}};
    for (int i = 0; i < NR; i++) begin
      logic [ADDR_W-1:0] a_s;
      logic [DATA_W-1:0] rd_s;
      logic              hit_s;
      logic              hit_j_s;
      logic              iss_hit_s;
      a_s   = raddr[i*ADDR_W +: ADDR_W];
      rd_s  = mem_q[a_s];
      hit_s = 1'b0;
      for (int j = 0; j < NW; j++) begin
        hit_j_s = (BYPASS != 0) && wvalid_s[j] && (waddr[j*ADDR_W +: ADDR_W] == a_s);
        rd_s    = hit_j_s ? wdata[j*DATA_W +: DATA_W] : rd_s;
        hit_s   = hit_s || hit_j_s;
      end
      rd_s      = ((ZERO_REG != 0) && (a_s == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : rd_s;
      iss_hit_s = iss_valid && (iss_addr == a_s);
      rdata[i*DATA_W +: DATA_W] = rd_s;
      rbusy[i] = busy_q[a_s] && !(hit_s && !iss_hit_s);
    end
  end

  assign busy_vec = busy_q;

`ifdef REG_FILE_MP_DUMP
  // Simulation-only trace of every committed register write
  always_ff @(posedge clk) begin
    for (int j = 0; j < NW; j++) begin
      if (!rst && wvalid_s[j]) begin
        $display("%t: x%0d <= 0x%08h", $time, waddr[j*ADDR_W +: ADDR_W],
                 wdata[j*DATA_W +: DATA_W]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: a 3-read/2-write bypassing instance and a
// 1-read/1-write non-bypassing instance checked against an array-based model.
module tb_reg_file_mp;

  typedef struct packed {
    logic [95:0] rd;
    logic [2:0]  rb;
    logic [31:0] bv;
    logic [31:0] rnb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [14:0] raddr = '0;
  logic [95:0] rdata;
  logic [2:0]  rbusy;
  logic [1:0]  we = '0;
  logic [9:0]  waddr = '0;
  logic [63:0] wdata = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic [31:0] busy_vec;
  logic [31:0] rdata_nb;
  logic [0:0]  rbusy_nb;
  logic [31:0] busy_vec_nb;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  logic [31:0] mem_m    [32];
  logic [31:0] mem_nb_m [32];
  logic [31:0] busy_m;

  reg_file_mp #(.ADDR_W(5), .DATA_W(32), .NR(3), .NW(2), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  reg_file_mp #(.ADDR_W(5), .DATA_W(32), .NR(1), .NW(1), .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .raddr(raddr[4:0]), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we[0]), .waddr(waddr[4:0]), .wdata(wdata[31:0]), .iss_valid(iss_valid),
    .iss_addr(iss_addr), .busy_vec(busy_vec_nb)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s[%0d] got=0x%08h expected=0x%08h at %0t", name, idx, got, want, $time);
    end
  endtask

  // One clock of stimulus: drive, predict this cycle's outputs, then commit the model
  task automatic step(input logic r, input logic [1:0] w,
                      input logic [4:0] a0, input logic [31:0] d0,
                      input logic [4:0] a1, input logic [31:0] d1,
                      input logic iv, input logic [4:0] ia,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic [4:0]  ra [3];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [31:0] v;
    logic        hit;
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = {a1, a0}; wdata = {d1, d0};
    iss_valid = iv; iss_addr = ia; raddr = {r2, r1, r0};
    ra[0] = r0; ra[1] = r1; ra[2] = r2;
    wa[0] = a0; wa[1] = a1; wd[0] = d0; wd[1] = d1;
    if (!r) begin
      for (int i = 0; i < 3; i++) begin
        v = mem_m[ra[i]];
        hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
          if (w[j] && wa[j] == ra[i] && ra[i] != 5'd0) begin
            v = wd[j];
            hit = 1'b1;
          end
        end
        if (ra[i] == 5'd0) v = 32'd0;
        e.rd[i*32 +: 32] = v;
        e.rb[i] = busy_m[ra[i]] && !(hit && !(iv && ia == ra[i]));
      end
      e.bv  = busy_m;
      e.rnb = (r0 == 5'd0) ? 32'd0 : mem_nb_m[r0];
      exp_q.push_back(e);
    end
    if (r) begin
      for (int k = 0; k < 32; k++) begin
        mem_m[k] = 32'd0;
        mem_nb_m[k] = 32'd0;
      end
      busy_m = 32'd0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (w[j]) begin
          if (wa[j] != 5'd0) mem_m[wa[j]] = wd[j];
          busy_m[wa[j]] = 1'b0;
        end
      end
      if (iv && ia != 5'd0) busy_m[ia] = 1'b1;
      if (w[0] && a0 != 5'd0) mem_nb_m[a0] = d0;
    end
  endtask

  // Monitor: compare each cycle's outputs against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("rdata", i, rdata[i*32 +: 32], e.rd[i*32 +: 32]);
        end
        check("rbusy", 0, {29'd0, rbusy}, {29'd0, e.rb});
        check("busy_vec", 0, busy_vec, e.bv);
        check("rdata_nobypass", 0, rdata_nb, e.rnb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    logic [1:0]  w;
    logic        iv;
    // reset, then reset state
    step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0);
    // write x5, issue x7, then reset clears both
    step(1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd7, 5'd5, 5'd7, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0);
    step(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0);
    // bypass vs. no bypass
    step(1'b0, 2'b01, 5'd3, 32'h12345678, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd0);
    // zero register
    step(1'b0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    // dual-write conflict, then disjoint dual write
    step(1'b0, 2'b11, 5'd10, 32'h1, 5'd10, 32'h2, 1'b0, 5'd0, 5'd10, 5'd10, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd11, 5'd12);
    step(1'b0, 2'b11, 5'd11, 32'hA, 5'd12, 32'hB, 1'b0, 5'd0, 5'd11, 5'd12, 5'd10);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd12, 5'd10);
    // scoreboard race on x9
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 2'b01, 5'd9, 32'h99, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    step(1'b0, 2'b10, 5'd0, 32'd0, 5'd9, 32'h9A, 1'b0, 5'd0, 5'd9, 5'd9, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0, 5'd0);
    // reset mid-operation
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd6, 5'd4, 5'd6, 5'd0);
    step(1'b1, 2'b01, 5'd4, 32'h55, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd6, 5'd0);
    step(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6, 5'd0);
    // randomized traffic over a small address range to provoke collisions
    for (int n = 0; n < 400; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      w  = 2'($urandom_range(0, 3));
      iv = 1'($urandom_range(0, 1));
      step(r, w, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
           iv, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
